// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/sequencing controller feeding the ALU.
// Owns PC, IR, carry/borrow flags, branch evaluation and control ops.
module cpu_control_unit #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk_pi,
  input  logic        reset_pi,
  output logic [15:0] imem_addr_po,
  input  logic [15:0] imem_data_pi,
  output logic [15:0] dmem_addr_po,
  output logic [15:0] dmem_wdata_po,
  output logic        dmem_we_po,
  input  logic [15:0] dmem_rdata_pi,
  output logic [2:0]  rs1_addr_po,
  output logic [2:0]  rs2_addr_po,
  output logic [2:0]  rd_addr_po,
  input  logic [15:0] reg1_data_pi,
  input  logic [15:0] reg2_data_pi,
  output logic        reg_we_po,
  output logic [15:0] reg_wdata_po,
  output logic        arith_1op_po,
  output logic        arith_2op_po,
  output logic        addi_po,
  output logic        subi_po,
  output logic        load_or_store_po,
  output logic        stc_cmd_po,
  output logic        stb_cmd_po,
  output logic [2:0]  alu_func_po,
  output logic [5:0]  immediate_po,
  output logic        carry_in_po,
  output logic        borrow_in_po,
  input  logic [15:0] alu_result_pi,
  input  logic        carry_out_pi,
  input  logic        borrow_out_pi,
  output logic        retire_po,
  output logic        halted_po
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] pc, ir, result_reg;
  logic [15:0] pc_inc, pc_nx, off, ir_cur;
  logic        carry, borrow;
  logic [3:0]  op, op_cur;
  logic        is_ls, is_ctl, is_stc, is_stb;
  logic        is_rst, is_halt, is_jump;
  logic        flag_op, taken;

  // During DECODE the IR is not yet loaded, so decode straight from imem
  assign ir_cur = (state == S_DECODE) ? imem_data_pi : ir;
  assign op     = ir[15:12];
  assign op_cur = ir_cur[15:12];

  assign is_ls   = (op == 4'h6) || (op == 4'h7);
  assign is_ctl  = (op == 4'hF);
  assign is_stc  = is_ctl && (ir[11:0] == 12'h001);
  assign is_stb  = is_ctl && (ir[11:0] == 12'h002);
  assign is_rst  = is_ctl && (ir[11:0] == 12'hAAA);
  assign is_halt = is_ctl && (ir[11:0] == 12'hFFF);
  assign is_jump = (op == 4'hC);
  assign flag_op = (op == 4'h1) || (op == 4'h2)
                || (op == 4'h4) || (op == 4'h5)
                || is_ls || is_ctl;

  assign pc_inc = pc + 16'd1;
  assign off    = {{10{ir[5]}}, ir[5:0]};

  always_comb begin
    taken = 1'b0;
    case (op)
      4'h8:    taken = (reg1_data_pi == reg2_data_pi);
      4'h9:    taken = (reg1_data_pi >= reg2_data_pi);
      4'hA:    taken = (reg1_data_pi <= reg2_data_pi);
      4'hB:    taken = carry;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_nx = pc_inc;
    unique case (1'b1)
      is_rst:  pc_nx = PC_RESET;
      is_jump: pc_nx = {pc[15:12], ir[11:0]};
      taken:   pc_nx = pc_inc + off;
      default: pc_nx = pc_inc;
    endcase
  end

  always_comb begin
    rs1_addr_po = 3'd0;
    rs2_addr_po = 3'd0;
    rd_addr_po  = 3'd0;
    case (op_cur)
      4'h1: begin
        rd_addr_po  = ir_cur[8:6];
        rs1_addr_po = ir_cur[5:3];
        rs2_addr_po = ir_cur[2:0];
      end
      4'h2: begin
        rd_addr_po  = ir_cur[8:6];
        rs1_addr_po = ir_cur[5:3];
      end
      4'h3: rd_addr_po = ir_cur[11:9];
      4'h4, 4'h5, 4'h6: begin
        rd_addr_po  = ir_cur[11:9];
        rs1_addr_po = ir_cur[8:6];
      end
      4'h7: begin
        rs2_addr_po = ir_cur[11:9];
        rs1_addr_po = ir_cur[8:6];
      end
      4'h8, 4'h9, 4'hA: begin
        rs1_addr_po = ir_cur[11:9];
        rs2_addr_po = ir_cur[8:6];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state      <= S_FETCH;
      pc         <= PC_RESET;
      ir         <= 16'h0000;
      result_reg <= 16'h0000;
      carry      <= 1'b0;
      borrow     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) ir <= imem_data_pi;
      if (state == S_EXEC) begin
        result_reg <= alu_result_pi;
        if (flag_op) begin
          carry  <= carry_out_pi;
          borrow <= borrow_out_pi;
        end
      end
      if (state == S_WB) begin
        pc <= pc_nx;
        if (is_rst) begin
          carry  <= 1'b0;
          borrow <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_nx         = state;
    arith_1op_po     = 1'b0;
    arith_2op_po     = 1'b0;
    addi_po          = 1'b0;
    subi_po          = 1'b0;
    load_or_store_po = 1'b0;
    stc_cmd_po       = 1'b0;
    stb_cmd_po       = 1'b0;
    dmem_we_po       = 1'b0;
    reg_we_po        = 1'b0;
    retire_po        = 1'b0;
    case (state)
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        state_nx         = is_ls ? S_MEM : S_WB;
        arith_2op_po     = (op == 4'h1);
        arith_1op_po     = (op == 4'h2);
        addi_po          = (op == 4'h4);
        subi_po          = (op == 4'h5);
        load_or_store_po = is_ls;
        stc_cmd_po       = is_stc;
        stb_cmd_po       = is_stb;
      end
      S_MEM: begin
        state_nx   = S_WB;
        dmem_we_po = (op == 4'h7);
      end
      S_WB: begin
        state_nx  = is_halt ? S_HALT : S_FETCH;
        reg_we_po = (op >= 4'h1) && (op <= 4'h6);
        retire_po = 1'b1;
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
    if (reset_pi) begin
      arith_1op_po     = 1'b0;
      arith_2op_po     = 1'b0;
      addi_po          = 1'b0;
      subi_po          = 1'b0;
      load_or_store_po = 1'b0;
      stc_cmd_po       = 1'b0;
      stb_cmd_po       = 1'b0;
      dmem_we_po       = 1'b0;
      reg_we_po        = 1'b0;
      retire_po        = 1'b0;
    end
  end

  always_comb begin
    reg_wdata_po = result_reg;
    if (op == 4'h3) reg_wdata_po = {7'd0, ir[8:0]};
    else if (op == 4'h6) reg_wdata_po = dmem_rdata_pi;
  end

  assign imem_addr_po  = pc;
  assign dmem_addr_po  = result_reg;
  assign dmem_wdata_po = reg2_data_pi;
  assign alu_func_po   = ir[11:9];
  assign immediate_po  = ir[5:0];
  assign carry_in_po   = carry;
  assign borrow_in_po  = borrow;
  assign halted_po     = (state == S_HALT) && !reset_pi;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed-program bench for cpu_control_unit with behavioural
// memories, register file and a small ALU.
module tb_cpu_control_unit;

  logic        clk_pi = 1'b0;
  logic        reset_pi;
  logic [15:0] imem_addr_po, imem_data_pi;
  logic [15:0] dmem_addr_po, dmem_wdata_po, dmem_rdata_pi;
  logic        dmem_we_po;
  logic [2:0]  rs1_addr_po, rs2_addr_po, rd_addr_po;
  logic [15:0] reg1_data_pi, reg2_data_pi;
  logic        reg_we_po;
  logic [15:0] reg_wdata_po;
  logic        arith_1op_po, arith_2op_po, addi_po, subi_po;
  logic        load_or_store_po, stc_cmd_po, stb_cmd_po;
  logic [2:0]  alu_func_po;
  logic [5:0]  immediate_po;
  logic        carry_in_po, borrow_in_po;
  logic [15:0] alu_result_pi;
  logic        carry_out_pi, borrow_out_pi;
  logic        retire_po, halted_po;

  cpu_control_unit dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi),
    .imem_addr_po(imem_addr_po), .imem_data_pi(imem_data_pi),
    .dmem_addr_po(dmem_addr_po), .dmem_wdata_po(dmem_wdata_po),
    .dmem_we_po(dmem_we_po), .dmem_rdata_pi(dmem_rdata_pi),
    .rs1_addr_po(rs1_addr_po), .rs2_addr_po(rs2_addr_po),
    .rd_addr_po(rd_addr_po),
    .reg1_data_pi(reg1_data_pi), .reg2_data_pi(reg2_data_pi),
    .reg_we_po(reg_we_po), .reg_wdata_po(reg_wdata_po),
    .arith_1op_po(arith_1op_po), .arith_2op_po(arith_2op_po),
    .addi_po(addi_po), .subi_po(subi_po),
    .load_or_store_po(load_or_store_po),
    .stc_cmd_po(stc_cmd_po), .stb_cmd_po(stb_cmd_po),
    .alu_func_po(alu_func_po), .immediate_po(immediate_po),
    .carry_in_po(carry_in_po), .borrow_in_po(borrow_in_po),
    .alu_result_pi(alu_result_pi),
    .carry_out_pi(carry_out_pi), .borrow_out_pi(borrow_out_pi),
    .retire_po(retire_po), .halted_po(halted_po)
  );

  always #5 clk_pi = ~clk_pi;

  logic [15:0] imem [0:65535];
  logic [15:0] dmem [0:255];
  logic [15:0] rf   [0:7];

  always @(posedge clk_pi) begin
    imem_data_pi  <= imem[imem_addr_po];
    dmem_rdata_pi <= dmem[dmem_addr_po[7:0]];
    if (dmem_we_po) dmem[dmem_addr_po[7:0]] <= dmem_wdata_po;
    if (reg_we_po) rf[rd_addr_po] <= reg_wdata_po;
  end

  assign reg1_data_pi = rf[rs1_addr_po];
  assign reg2_data_pi = rf[rs2_addr_po];

  logic [16:0] t;
  always_comb begin
    alu_result_pi = 16'h0000;
    carry_out_pi  = carry_in_po;
    borrow_out_pi = borrow_in_po;
    t = 17'd0;
    if (addi_po) begin
      t = {1'b0, reg1_data_pi} + {11'd0, immediate_po};
      alu_result_pi = t[15:0];
      carry_out_pi  = t[16];
    end
    if (subi_po) begin
      alu_result_pi = reg1_data_pi - {10'd0, immediate_po};
      borrow_out_pi = reg1_data_pi < {10'd0, immediate_po};
    end
    if (load_or_store_po)
      alu_result_pi = reg1_data_pi + {10'd0, immediate_po};
    if (arith_2op_po) begin
      if (alu_func_po == 3'd3) begin
        alu_result_pi = reg1_data_pi - reg2_data_pi
                      - {15'd0, borrow_in_po};
        borrow_out_pi = {1'b0, reg1_data_pi}
                      < ({1'b0, reg2_data_pi} + {16'd0, borrow_in_po});
      end else begin
        t = {1'b0, reg1_data_pi} + {1'b0, reg2_data_pi};
        alu_result_pi = t[15:0];
        carry_out_pi  = t[16];
      end
    end
    if (arith_1op_po) alu_result_pi = reg1_data_pi + 16'd1;
    if (stc_cmd_po) carry_out_pi = 1'b1;
    if (stb_cmd_po) borrow_out_pi = 1'b1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          st_we, cyc;
  logic [15:0] st_addr, st_data, wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we, got_ret;

  // Starts at a FETCH negedge, ends at the next instruction's FETCH
  task automatic step();
    cyc = 1; st_we = 0; got_ret = 1'b0;
    wb_we = 1'b0; wb_rd = 3'd0; wb_data = 16'h0;
    st_addr = 16'h0; st_data = 16'h0;
    while (!got_ret && cyc < 12) begin
      @(negedge clk_pi);
      cyc++;
      if (dmem_we_po) begin
        st_we++;
        st_addr = dmem_addr_po;
        st_data = dmem_wdata_po;
      end
      if (retire_po) begin
        got_ret = 1'b1;
        wb_we   = reg_we_po;
        wb_rd   = rd_addr_po;
        wb_data = reg_wdata_po;
      end
    end
    chk("retire_seen", {31'd0, got_ret}, 32'd1);
    @(negedge clk_pi);
  endtask

  task automatic run(input string tag, input int ecyc,
                     input logic [15:0] epc);
    step();
    chk({tag, "_cyc"}, cyc, ecyc);
    chk({tag, "_pc"}, {16'd0, imem_addr_po}, {16'd0, epc});
  endtask

  task automatic wbchk(input string tag, input logic [2:0] rd,
                       input logic [15:0] d);
    chk({tag, "_we"}, {31'd0, wb_we}, 32'd1);
    chk({tag, "_rd"}, {29'd0, wb_rd}, {29'd0, rd});
    chk({tag, "_wd"}, {16'd0, wb_data}, {16'd0, d});
  endtask

  initial begin
    int quiet, hold;
    for (int i = 0; i < 65536; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[0] = 16'hFFFE;
    rf[4] = 16'hBEEF;
    imem[16'h0000] = 16'h4205;
    imem[16'h0001] = 16'h3205;
    imem[16'h0002] = 16'h3405;
    imem[16'h0003] = 16'hC010;
    imem[16'h0010] = 16'hF002;
    imem[16'h0011] = 16'h16CA;
    imem[16'h0012] = 16'hC005;
    imem[16'h0005] = 16'h82BE;
    imem[16'h0004] = 16'hC040;
    imem[16'h0040] = 16'h92C5;
    imem[16'h0041] = 16'h4A41;
    imem[16'h0042] = 16'hB005;
    imem[16'h0043] = 16'hF001;
    imem[16'h0044] = 16'hB004;
    imem[16'h0049] = 16'h3208;
    imem[16'h004A] = 16'h7842;
    imem[16'h004B] = 16'h6C42;
    imem[16'h004C] = 16'hFAAA;
    imem[16'hFFFF] = 16'hC123;
    imem[16'hF123] = 16'hF001;
    imem[16'hF124] = 16'h7842;

    reset_pi = 1'b1;
    repeat (2) @(negedge clk_pi);
    chk("rst_pc", {16'd0, imem_addr_po}, 32'h0);
    chk("rst_retire", {31'd0, retire_po}, 32'd0);
    chk("rst_halted", {31'd0, halted_po}, 32'd0);
    chk("rst_regwe", {31'd0, reg_we_po}, 32'd0);
    reset_pi = 1'b0;

    run("addi", 4, 16'h0001);
    wbchk("addi", 3'd1, 16'h0003);
    chk("addi_carry", {31'd0, carry_in_po}, 32'd1);
    run("movi1", 4, 16'h0002);
    wbchk("movi1", 3'd1, 16'h0005);
    run("movi2", 4, 16'h0003);
    run("j010", 4, 16'h0010);
    run("stb", 4, 16'h0011);
    chk("stb_we", {31'd0, wb_we}, 32'd0);
    chk("stb_borrow", {31'd0, borrow_in_po}, 32'd1);
    run("subb", 4, 16'h0012);
    wbchk("subb", 3'd3, 16'hFFFF);
    chk("subb_borrow", {31'd0, borrow_in_po}, 32'd1);
    run("j005", 4, 16'h0005);
    run("beq_back", 4, 16'h0004);
    run("j040", 4, 16'h0040);
    run("bge_nt", 4, 16'h0041);
    run("addi5", 4, 16'h0042);
    wbchk("addi5", 3'd5, 16'h0006);
    chk("addi5_carry", {31'd0, carry_in_po}, 32'd0);
    run("bc_nt", 4, 16'h0043);
    run("stc", 4, 16'h0044);
    chk("stc_carry", {31'd0, carry_in_po}, 32'd1);
    run("bc_t", 4, 16'h0049);
    run("movi8", 4, 16'h004A);
    run("stor", 5, 16'h004B);
    chk("stor_wecnt", st_we, 32'd1);
    chk("stor_addr", {16'd0, st_addr}, 32'h000A);
    chk("stor_data", {16'd0, st_data}, 32'hBEEF);
    chk("stor_regwe", {31'd0, wb_we}, 32'd0);
    run("load", 5, 16'h004C);
    wbchk("load", 3'd6, 16'hBEEF);
    chk("load_wecnt", st_we, 32'd0);
    run("reset_op", 4, 16'h0000);
    chk("reset_op_c", {31'd0, carry_in_po}, 32'd0);
    chk("reset_op_b", {31'd0, borrow_in_po}, 32'd0);

    imem[16'h0000] = 16'h827E;
    run("beq_wrap", 4, 16'hFFFF);
    run("j_hi", 4, 16'hF123);
    run("stc2", 4, 16'hF124);
    chk("stc2_carry", {31'd0, carry_in_po}, 32'd1);

    repeat (3) @(negedge clk_pi);
    reset_pi = 1'b1;
    #1;
    chk("mrst_we", {31'd0, dmem_we_po}, 32'd0);
    @(negedge clk_pi);
    chk("mrst_pc", {16'd0, imem_addr_po}, 32'h0);
    chk("mrst_c", {31'd0, carry_in_po}, 32'd0);
    chk("mrst_b", {31'd0, borrow_in_po}, 32'd0);
    reset_pi = 1'b0;
    imem[16'h0000] = 16'hFFFF;

    step();
    chk("halt_cyc", cyc, 32'd4);
    quiet = 0; hold = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted_po) hold++;
      if (retire_po | reg_we_po | dmem_we_po | addi_po | subi_po
          | arith_1op_po | arith_2op_po | load_or_store_po
          | stc_cmd_po | stb_cmd_po) quiet++;
      @(negedge clk_pi);
    end
    chk("halt_hold", hold, 32'd20);
    chk("halt_quiet", quiet, 32'd0);
    reset_pi = 1'b1;
    #1;
    chk("halt_rst", {31'd0, halted_po}, 32'd0);
    @(negedge clk_pi);
    reset_pi = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Multi-cycle fetch/decode/sequencing controller that sits directly upstream of the ALU. It fetches 16-bit instructions, decodes the opcode and function fields into ALU control strobes, and sequences memory access and register writeback. It owns the PC, the carry/borrow flag registers (fed back to the ALU), branch evaluation, and the STC/STB/RESET/HALT control instructions.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset_pi and on the RESET control instruction

Ports:
clk_pi  in  1  single clock; all state updates on rising edge
reset_pi  in  1  synchronous, active-high reset
imem_addr_po  out  16  instruction address (= PC)
imem_data_pi  in  16  instruction word; valid the cycle after imem_addr_po is presented
dmem_addr_po  out  16  data address (latched ALU result)
dmem_wdata_po  out  16  store data (reg2_data_pi)
dmem_we_po  out  1  data write strobe
dmem_rdata_pi  in  16  load data; valid the cycle after dmem_addr_po is presented
rs1_addr_po / rs2_addr_po / rd_addr_po  out  3 each  register file addresses
reg1_data_pi / reg2_data_pi  in  16 each  register file async read data
reg_we_po  out  1  register file write enable
reg_wdata_po  out  16  writeback data
arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po, stc_cmd_po, stb_cmd_po  out  1 each  ALU strobes
alu_func_po  out  3  ALU function, IR[11:9]
immediate_po  out  6  IR[5:0]
carry_in_po / borrow_in_po  out  1 each  current carry/borrow flags
alu_result_pi  in  16  ALU result
carry_out_pi / borrow_out_pi  in  1 each  ALU next-flag outputs
retire_po  out  1  one-cycle pulse per completed instruction
halted_po  out  1  high in HALT state

Behaviour:
- Instruction formats, opcode in IR[15:12]. ARITH_2OP(1): func[11:9], rd[8:6], rs1[5:3], rs2[2:0]. ARITH_1OP(2): func[11:9], rd[8:6], rs1[5:3]. MOVI(3): rd[11:9], imm9[8:0], zero-extended. ADDI(4)/SUBI(5)/LOAD(6): rd[11:9], rs1[8:6], imm6[5:0]. STOR(7): rs2 (data)[11:9], rs1 (base)[8:6], imm6. BEQ(8)/BGE(9)/BLE(A): rs1[11:9], rs2[8:6], off6[5:0], signed. BC(B): off6. J(C): target = {PC[15:12], IR[11:0]}. CONTROL(F): IR[11:0] = 001 STC, 002 STB, AAA RESET, FFF HALT. NOP(0), unused opcodes, and unused CONTROL codes retire as NOP.
- FSM states: FETCH -> DECODE -> EXEC -> (MEM if LOAD/STOR) -> WB -> FETCH; HALT is absorbing. Latency: 4 cycles per instruction, 5 for LOAD/STOR.
- FETCH: imem_addr_po = PC. DECODE: IR <= imem_data_pi. Register addresses are combinational from IR and valid from DECODE onward.
- EXEC: ALU strobes asserted from IR (zero in all other states). STC/STB strobes are asserted for their CONTROL codes. At end of EXEC: result_reg <= alu_result_pi; carry <= carry_out_pi; borrow <= borrow_out_pi. Flags are written only on this edge and only for opcodes 1, 2, 4, 5, 6, 7, F.
- BEQ/BGE/BLE compare reg1/reg2 as unsigned (==, >=, <=). BC is taken if the carry flag is 1. Taken target = PC+1+sext(off6); not taken = PC+1. All PC arithmetic is mod 2^16.
- MEM, STOR: dmem_we_po=1 for exactly 1 cycle; dmem_addr_po = result_reg.
- MEM, LOAD: address is presented and no write occurs; data is captured in WB.
- WB: reg_we_po=1 for opcodes 1, 2, 3, 4, 5, 6. Data: ALU/ADDI/SUBI use result_reg; MOVI uses imm9; LOAD uses dmem_rdata_pi. retire_po=1 and the PC updates.
- RESET instruction: at WB, PC <= PC_RESET and both flags <= 0; the PC+1 update is overridden.
- HALT: entered at WB with retire_po=1. Stays in HALT until reset_pi; no strobes while halted.
- reset_pi (any state, including mid-MEM): next state FETCH, PC=PC_RESET, IR=0, flags=0, result_reg=0. All write/strobe outputs are 0 in the reset cycle; halted_po=0.

Test Plan:
- ADDI sequence: reset; imem[0]=4'h4 rd=1 rs1=0 imm=5 with r0=16'hFFFE -> EXEC edge latches 16'h0003, carry=1. WB writes r1=0003 in cycle 4; retire_po pulses once; PC=1.
- SUBB using the borrow flag: STB, then ARITH_2OP SUBB with r1=5, r2=5 -> borrow_in_po=1, result 16'hFFFF, borrow=1.
- LOAD/STOR: STOR r2=16'hBEEF at r1(=8)+2 -> dmem_we_po high exactly 1 cycle at addr 10. LOAD back returns BEEF to rd; each instruction takes 5 cycles.
- Branches: BEQ equal regs, off6=6'h3E (-2) at PC=5 -> PC=4. BGE with r1<r2 -> PC=6. BC with carry=0 -> not taken.
- Control ops: J 12'h123 at PC=16'h5000 -> PC=5123. RESET clears flags and PC=0. HALT asserts halted_po and holds with no strobes for 20 cycles.
- reset_pi asserted during a STOR's MEM cycle -> no dmem_we_po pulse, FETCH next cycle at PC_RESET, flags 0.
